// File: rtl/pong_pkg.sv
// Shared definitions for the pong frame sequencer: FSM state encoding,
// X/Y coordinate packing helpers and score byte indices.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SERVE  = 3'd1,
      READY  = 3'd2,
      ISSUE  = 3'd3,
      WAIT   = 3'd4,
      COMMIT = 3'd5,
      OVER   = 3'd6
   } state_t;

   // Score word layout: right player in byte 1, left player in byte 0.
   localparam int SCORE_LEFT_IDX  = 0;
   localparam int SCORE_RIGHT_IDX = 1;

   // Coordinates travel as {X, Y} in one 32-bit word.
   function automatic logic [31:0] pack_xy(input logic [15:0] x, input logic [15:0] y);
      return {x, y};
   endfunction

   function automatic logic [15:0] unpack_x(input logic [31:0] p);
      return p[31:16];
   endfunction

   function automatic logic [15:0] unpack_y(input logic [31:0] p);
      return p[15:0];
   endfunction

   function automatic logic [7:0] score_byte(input logic [15:0] s, input int idx);
      return s[idx*8 +: 8];
   endfunction

   // Lowest paddle top position that keeps the paddle on screen; a screen
   // shorter than the paddle pins it at the top.
   function automatic logic [15:0] paddle_max_y(input logic [15:0] height,
                                                input logic [15:0] len);
      return (height > len) ? (height - len) : 16'd0;
   endfunction

endpackage

// File: rtl/paddle_input_ctrl.sv
// Right paddle Y register driven by the player buttons. Moves one step per
// enable pulse, saturating at 0 and at max_y; load recentres it on a serve.
module paddle_input_ctrl import pong_pkg::*; #(
   parameter int PADDLE_STEP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_y,
   input  logic        en,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic [15:0] max_y,
   output logic [15:0] y
);

   localparam logic [16:0] STEP17 = 17'(PADDLE_STEP);

   logic [16:0] up_sum;
   logic [16:0] dn_sum;
   logic [15:0] y_next;

   // Compute the saturated next position in 17 bits so neither edge can wrap.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      y_next = y;
      up_sum = {1'b0, y} - STEP17;
      dn_sum = {1'b0, y} + STEP17;
      if (btn_up && !btn_down) begin
         y_next = up_sum[16] ? 16'd0 : up_sum[15:0];
      end else if (btn_down && !btn_up) begin
         y_next = (dn_sum > {1'b0, max_y}) ? max_y : dn_sum[15:0];
      end
   end

   // Position register: serve load has priority over a button step.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         y <= 16'd0;
      end else if (load) begin
         y <= load_y;
      end else if (en) begin
         y <= y_next;
      end
   end

endmodule

// File: rtl/pong_frame_sequencer.sv
// Pong frame sequencer: serves the ball, issues operands to the game core
// once per frame tick, waits CORE_LATENCY cycles, commits the results and
// tracks score / end of game.
// Optional build macro PONG_PAUSE_EN adds a 'pause' level input that blocks
// frame ticks in READY and freezes the latency counter in WAIT.
module pong_frame_sequencer import pong_pkg::*; #(
   parameter int CORE_LATENCY = 1,
   parameter int PADDLE_STEP  = 2,
   parameter int PADDLE_LEN   = 16,
   parameter int WIN_SCORE    = 11,
   parameter int SERVE_VX     = 1,
   parameter int SERVE_VY     = 1
) (
   input  logic        clk,
   input  logic        rst,
`ifdef PONG_PAUSE_EN
   input  logic        pause,
`endif
   input  logic        frameTick,
   input  logic        startGame,
   input  logic        btnUp,
   input  logic        btnDown,
   input  logic [31:0] dimensions,
   output logic [31:0] ballPosition,
   output logic [31:0] ballVelocity,
   output logic [31:0] leftPaddlePosition,
   output logic [31:0] rightPaddlePosition,
   output logic        coreRst,
   input  logic [15:0] scoreIn,
   input  logic [31:0] ballPositionIn,
   input  logic [31:0] ballVelocityIn,
   input  logic [31:0] leftPaddlePositionIn,
   output logic        frameDone,
   output logic        gameOver,
   output logic [1:0]  winner,
   output logic        overrun
);

   localparam logic [7:0]  LAT_INIT = 8'(CORE_LATENCY);
   localparam logic [7:0]  WIN_B    = 8'(WIN_SCORE);
   localparam logic [15:0] LEN_W    = 16'(PADDLE_LEN);
   localparam logic [15:0] VX_POS   = 16'(SERVE_VX);
   localparam logic [15:0] VX_NEG   = 16'(-SERVE_VX);
   localparam logic [15:0] VY_POS   = 16'(SERVE_VY);

   state_t      state_q, state_d;
   logic [7:0]  lat_cnt_q, lat_cnt_d;

   logic [31:0] ball_pos_q, ball_vel_q, left_pad_q;
   logic [15:0] right_x_q;
   logic [15:0] right_y;
   logic [15:0] score_q;
   logic        serve_left_q;
   logic        core_rst_q, frame_done_q, game_over_q, overrun_q;
   logic [1:0]  winner_q;

   logic        pause_act;
   logic [15:0] width, height, max_y;
   logic [7:0]  right_new, left_new;
   logic        right_win, left_win, game_end, score_changed, right_scored;
   logic        start_accept, tick_overrun;

`ifdef PONG_PAUSE_EN
   assign pause_act = pause;
`else
   assign pause_act = 1'b0;
`endif

   assign width  = unpack_x(dimensions);
   assign height = unpack_y(dimensions);
   assign max_y  = paddle_max_y(height, LEN_W);

   assign right_new     = score_byte(scoreIn, SCORE_RIGHT_IDX);
   assign left_new      = score_byte(scoreIn, SCORE_LEFT_IDX);
   assign right_win     = (right_new >= WIN_B);
   assign left_win      = (left_new >= WIN_B);
   assign game_end      = right_win || left_win;
   assign score_changed = (scoreIn != score_q);
   assign right_scored  = (right_new != score_byte(score_q, SCORE_RIGHT_IDX));

   assign start_accept = startGame && ((state_q == IDLE) || (state_q == OVER));
   assign tick_overrun = frameTick && ((state_q == ISSUE) || (state_q == WAIT) ||
                                       (state_q == COMMIT) || (state_q == SERVE));

   // State register and core-latency counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         lat_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

   // Next-state and counter logic for the frame handshake.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         IDLE:    if (startGame) state_d = SERVE;
         SERVE:   state_d = READY;
         READY:   if (frameTick && !pause_act) state_d = ISSUE;
         ISSUE: begin
            lat_cnt_d = LAT_INIT;
            state_d   = WAIT;
         end
         WAIT: begin
            if (!pause_act) begin
               if (lat_cnt_q <= 8'd1) begin
                  lat_cnt_d = 8'd0;
                  state_d   = COMMIT;
               end else begin
                  lat_cnt_d = lat_cnt_q - 8'd1;
               end
            end
         end
         COMMIT: begin
            if (game_end)           state_d = OVER;
            else if (score_changed) state_d = SERVE;
            else                    state_d = READY;
         end
         OVER:    if (startGame) state_d = SERVE;
         default: state_d = IDLE;
      endcase
   end

   // Operand registers, score tracking and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ball_pos_q   <= '0;
         ball_vel_q   <= '0;
         left_pad_q   <= '0;
         right_x_q    <= '0;
         score_q      <= '0;
         serve_left_q <= 1'b0;
         core_rst_q   <= 1'b1;
         frame_done_q <= 1'b0;
         game_over_q  <= 1'b0;
         winner_q     <= 2'b00;
         overrun_q    <= 1'b0;
      end else begin
         core_rst_q   <= (state_d == SERVE);
         frame_done_q <= (state_d == COMMIT);

         if (start_accept) begin
            score_q      <= '0;
            serve_left_q <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            overrun_q    <= 1'b0;
         end else if (tick_overrun) begin
            overrun_q <= 1'b1;
         end

         if (state_q == SERVE) begin
            ball_pos_q <= pack_xy(width >> 1, height >> 1);
            ball_vel_q <= pack_xy(serve_left_q ? VX_NEG : VX_POS, VY_POS);
            left_pad_q <= pack_xy(16'd0, max_y >> 1);
            right_x_q  <= width - 16'd1;
         end

         if (state_q == COMMIT) begin
            ball_pos_q <= ballPositionIn;
            ball_vel_q <= ballVelocityIn;
            left_pad_q <= leftPaddlePositionIn;
            score_q    <= scoreIn;
            if (game_end) begin
               game_over_q <= 1'b1;
               winner_q    <= {right_win, left_win};
            end else if (score_changed) begin
               // Serve toward the scorer: a left-player point sends vx negative.
               serve_left_q <= !right_scored;
            end
         end
      end
   end

   paddle_input_ctrl #(
      .PADDLE_STEP (PADDLE_STEP)
   ) u_right_paddle (
      .clk      (clk),
      .rst      (rst),
      .load     (state_q == SERVE),
      .load_y   (max_y >> 1),
      .en       (state_q == COMMIT),
      .btn_up   (btnUp),
      .btn_down (btnDown),
      .max_y    (max_y),
      .y        (right_y)
   );

   assign ballPosition        = ball_pos_q;
   assign ballVelocity        = ball_vel_q;
   assign leftPaddlePosition  = left_pad_q;
   assign rightPaddlePosition = pack_xy(right_x_q, right_y);
   assign coreRst             = core_rst_q;
   assign frameDone           = frame_done_q;
   assign gameOver            = game_over_q;
   assign winner              = winner_q;
   assign overrun             = overrun_q;

endmodule

// File: doc/pong_frame_sequencer.md
PONG_FRAME_SEQUENCER -- requirements
Module: pong_frame_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset. Ports are named clk and rst, consistent with the rest of the codebase.
REQ-002 Parameters:
- CORE_LATENCY, default 1: cycles from operand issue to valid game-core results.
- PADDLE_STEP, default 2: right-paddle Y step per frame.
- PADDLE_LEN, default 16: paddle height in pixels.
- WIN_SCORE, default 11: score byte that ends a game.
- SERVE_VX, default 1: serve speed magnitude on X.
- SERVE_VY, default 1: serve speed magnitude on Y.
REQ-003 Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- frameTick  in  1  one-cycle frame strobe
- startGame  in  1  one-cycle start pulse
- btnUp  in  1  level; move right paddle up
- btnDown  in  1  level; move right paddle down
- dimensions  in  32  width [31:16], height [15:0]
- ballPosition  out  32  operand to core: X [31:16], Y [15:0]
- ballVelocity  out  32  operand to core: signed vx [31:16], signed vy [15:0]
- leftPaddlePosition  out  32  operand to core, same packing as ballPosition
- rightPaddlePosition  out  32  operand to core, same packing as ballPosition
- coreRst  out  1  reset to game core
- scoreIn  in  16  core score: right player [15:8], left player [7:0]
- ballPositionIn  in  32  core result
- ballVelocityIn  in  32  core result
- leftPaddlePositionIn  in  32  core result
- frameDone  out  1  one-cycle pulse on commit
- gameOver  out  1  level
- winner  out  2  [1] right player, [0] left player
- overrun  out  1  sticky flag

Function
REQ-004 FSM states: IDLE, SERVE, READY, ISSUE, WAIT, COMMIT, OVER. The state encoding is an enum in the shared package.
REQ-005 IDLE: startGame SHALL move to SERVE. Every other input is ignored in IDLE.
REQ-006 SERVE, single cycle:
- Assert coreRst.
- Ball goes to (width>>1, height>>1).
- Both paddles go to Y = (height-PADDLE_LEN)>>1, with left X = 0 and right X = width-1.
- Velocity is (+SERVE_VX, +SERVE_VY) on the first serve. After a score, vx points toward the player who scored.
- Next state is READY.
REQ-007 READY: frameTick SHALL move to ISSUE and drive the operand registers onto the outputs.
REQ-008 ISSUE to WAIT: a down-counter is loaded with CORE_LATENCY. The FSM moves to COMMIT when the counter reaches 0. Operand outputs SHALL stay stable throughout ISSUE and WAIT.
REQ-009 COMMIT, single cycle:
- Latch ballPositionIn, ballVelocityIn and leftPaddlePositionIn into the operand registers.
- Apply the right-paddle update (REQ-010).
- Pulse frameDone.
- Compare scoreIn with the previously latched score: if it changed, go to SERVE; otherwise go to READY.
REQ-010 Right-paddle Y update, applied once per COMMIT:
- btnUp alone: Y -= PADDLE_STEP, saturating at 0.
- btnDown alone: Y += PADDLE_STEP, saturating at height-PADDLE_LEN.
- Both buttons or neither: Y holds.
- Arithmetic is 17-bit, so there is no wrap-around.
REQ-011 End of game: if either score byte is >= WIN_SCORE at COMMIT, the FSM SHALL go to OVER, assert gameOver and set winner. A simultaneous score change does not trigger a serve.
REQ-012 OVER: startGame SHALL go to SERVE, clear the latched score, clear gameOver and winner, and assert coreRst.
REQ-013 A frameTick that arrives in ISSUE, WAIT, COMMIT or SERVE SHALL be dropped and SHALL set overrun. A frameTick in IDLE or OVER is ignored and does not set overrun. overrun clears only on rst or startGame.
REQ-014 If startGame and frameTick arrive in the same cycle in OVER, startGame wins and the tick is dropped without setting overrun.

Reset
REQ-015 rst SHALL asynchronously force the following, including mid-frame:
- state = IDLE;
- all operand outputs = 0;
- coreRst = 1 while rst is high;
- frameDone, gameOver, winner and overrun = 0;
- latched score = 0.
REQ-016 After rst deasserts, outputs SHALL hold their reset values until the first startGame.

Configuration
REQ-017 With macro PONG_PAUSE_EN defined:
- A pause input (1 bit, level) is added.
- While pause is high in READY, frameTick is ignored and does not set overrun.
- While pause is high in WAIT, the latency counter freezes.
REQ-018 Without PONG_PAUSE_EN: there is no pause port and behaviour is exactly REQ-004 to REQ-016.

Structure
REQ-019 pong_pkg SHALL hold:
- the FSM state enum;
- the X/Y pack and unpack functions;
- the score byte index constants.
REQ-020 Sub-module paddle_input_ctrl SHALL implement REQ-010, purely registered and updated on a one-cycle enable pulse from COMMIT.

Verification
REQ-021 dimensions=0x00A0_0078, startGame: one cycle after SERVE, ballPosition=0x0050_003C, velocity=0x0001_0001, paddle Y=0x34.
REQ-022 frameTick, CORE_LATENCY=1, core returns ball 0x0051_003D: frameDone pulses 3 cycles after the tick, and ballPosition=0x0051_003D afterwards.
REQ-023 btnDown held for 60 frames, height 0x78: right Y saturates at 0x68 and never exceeds it. Then btnUp and btnDown held together: Y holds.
REQ-024 scoreIn changes 0x0000 to 0x0100 at COMMIT: state goes to SERVE, coreRst pulses, ball recentres, vx=+1.
REQ-025 scoreIn=0x0B03 at COMMIT: gameOver=1 and winner=2'b10. A frameTick in OVER has no effect, and startGame restarts the game.
REQ-026 frameTick in WAIT sets overrun. rst asserted mid-WAIT immediately forces IDLE and zero outputs.
